mem_arbiter: RTL and testbench

Arbitrates the single shared memory bus between the instruction-fetch port (IF stage) and the load/store port (MEM stage) of the pipelined MIPS core. Each port gets a request/done handshake. The bus side uses a split address/data handshake. The block produces per-port stall signals so the hazard unit can freeze the pipeline while a port waits. Byte enables for stores arrive already formed from the MEM-stage store-select logic.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/arb_cmd_reg.sv | 51 +++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM memory-bus arbiter: FSM state encoding and
// command-field widths.
package mem_arbiter_pkg;

  localparam int WSTRB_W = 4;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_ADDR = 3'd1,
    ARB_D_WAIT = 3'd2,
    ARB_I_ADDR = 3'd3,
    ARB_I_WAIT = 3'd4
  } arb_state_e;

  function automatic logic is_wait(input arb_state_e s);
    return (s == ARB_D_WAIT) || (s == ARB_I_WAIT);
  endfunction

endpackage

// File: rtl/arb_cmd_reg.sv
// Latched bus command (wr, wstrb, addr, wdata): loaded on grant, frozen until
// the next grant, cleared by synchronous reset.
module arb_cmd_reg
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               wr_i,
  input  logic [WSTRB_W-1:0] wstrb_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic               wr_o,
  output logic [WSTRB_W-1:0] wstrb_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [DATA_W-1:0]  wdata_o
);

  logic               wr_q;
  logic [WSTRB_W-1:0] wstrb_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load_i) begin
      wr_q    <= wr_i;
      wstrb_q <= wstrb_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end else begin
      wr_q    <= wr_q;
      wstrb_q <= wstrb_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  assign wr_o    = wr_q;
  assign wstrb_o = wstrb_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one split-handshake memory bus between the
// MEM-stage load/store port (high priority) and the IF-stage fetch port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic [ADDR_W-1:0]  inst_addr,
  output logic [DATA_W-1:0]  inst_rdata,
  output logic               inst_done,
  output logic               inst_stall,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [WSTRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [DATA_W-1:0]  data_wdata,
  output logic [DATA_W-1:0]  data_rdata,
  output logic               data_done,
  output logic               data_stall,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [WSTRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,
  input  logic [DATA_W-1:0]  mem_rdata
);

  arb_state_e         state_q, state_d;
  logic               drain_q, drain_d;
  logic               mem_req_q, mem_req_d;
  logic               inst_done_q, inst_done_d;
  logic               data_done_q, data_done_d;
  logic [DATA_W-1:0]  inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
  logic               grant_data, grant_inst;
  logic               sel_wr;
  logic [WSTRB_W-1:0] sel_wstrb;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               done_bubble;

  // A port whose done is pulsing is satisfied; nothing is granted that cycle.
  assign done_bubble = inst_done_q | data_done_q;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    grant_data   = 1'b0;
    grant_inst   = 1'b0;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (drain_q) begin
          drain_d = ~mem_data_ok;
        end else if (done_bubble) begin
          state_d = ARB_IDLE;
        end else if (data_req) begin
          grant_data = 1'b1;
          state_d    = ARB_D_ADDR;
        end else if (inst_req) begin
          grant_inst = 1'b1;
          state_d    = ARB_I_ADDR;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_D_ADDR: begin
        if (mem_addr_ok) state_d = ARB_D_WAIT;
        else             state_d = ARB_D_ADDR;
      end
      ARB_I_ADDR: begin
        if (mem_addr_ok) state_d = ARB_I_WAIT;
        else             state_d = ARB_I_ADDR;
      end
      ARB_D_WAIT: begin
        if (mem_data_ok) begin
          data_done_d  = 1'b1;
          data_rdata_d = mem_rdata;
          state_d      = ARB_IDLE;
        end else begin
          state_d = ARB_D_WAIT;
        end
      end
      ARB_I_WAIT: begin
        if (mem_data_ok) begin
          inst_done_d  = 1'b1;
          inst_rdata_d = mem_rdata;
          state_d      = ARB_IDLE;
        end else begin
          state_d = ARB_I_WAIT;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    mem_req_d = (state_d == ARB_D_ADDR) || (state_d == ARB_I_ADDR);
  end

  // Reset mid-WAIT leaves a data_ok in flight on the bus; drain swallows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      drain_q      <= is_wait(state_q) | (drain_q & ~mem_data_ok);
      mem_req_q    <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      mem_req_q    <= mem_req_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Grant-select mux: fetches are always reads with no byte enables.
  always_comb begin
    if (grant_data) begin
      sel_wr    = data_wr;
      sel_wstrb = data_wstrb;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
    end else begin
      sel_wr    = 1'b0;
      sel_wstrb = '0;
      sel_addr  = inst_addr;
      sel_wdata = '0;
    end
  end

  arb_cmd_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmd (
    .clk    (clk),
    .clr_i  (rst),
    .load_i (grant_data | grant_inst),
    .wr_i   (sel_wr),
    .wstrb_i(sel_wstrb),
    .addr_i (sel_addr),
    .wdata_i(sel_wdata),
    .wr_o   (mem_wr),
    .wstrb_o(mem_wstrb),
    .addr_o (mem_addr),
    .wdata_o(mem_wdata)
  );

  assign mem_req    = mem_req_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_stall = inst_req & ~inst_done_q;
  assign data_stall = data_req & ~data_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations at the key cycles of each scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done, inst_stall;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_done, data_stall;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done), .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, which phase it is in, and what was latched.
  int          m_owner = 0;          // 0 none, 1 data port, 2 fetch port
  bit          m_addr_phase = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_valid = 1'b0;
  bit          e_i_done = 1'b0, e_d_done = 1'b0;
  logic        e_wr = 1'b0;
  logic [3:0]  e_wstrb = 4'h0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_i_rdata = 32'h0, e_d_rdata = 32'h0;

  always @(posedge clk) begin
    bit was_done;
    if (rst) begin
      m_drain      = ((m_owner != 0) && !m_addr_phase) || (m_drain && !mem_data_ok);
      m_owner      = 0;
      m_addr_phase = 1'b0;
      e_i_done = 1'b0; e_d_done = 1'b0;
      e_wr = 1'b0; e_wstrb = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
      e_i_rdata = 32'h0; e_d_rdata = 32'h0;
      m_valid = 1'b1;
    end else begin
      was_done = e_i_done || e_d_done;
      e_i_done = 1'b0; e_d_done = 1'b0;
      if (m_owner == 0) begin
        if (m_drain) begin
          if (mem_data_ok) m_drain = 1'b0;
        end else if (!was_done && data_req) begin
          m_owner = 1; m_addr_phase = 1'b1;
          e_wr = data_wr; e_wstrb = data_wstrb; e_addr = data_addr; e_wdata = data_wdata;
        end else if (!was_done && inst_req) begin
          m_owner = 2; m_addr_phase = 1'b1;
          e_wr = 1'b0; e_wstrb = 4'h0; e_addr = inst_addr; e_wdata = 32'h0;
        end
      end else if (m_addr_phase) begin
        if (mem_addr_ok) m_addr_phase = 1'b0;
      end else if (mem_data_ok) begin
        if (m_owner == 1) begin e_d_done = 1'b1; e_d_rdata = mem_rdata; end
        else begin e_i_done = 1'b1; e_i_rdata = mem_rdata; end
        m_owner = 0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model, mid-cycle.
  always @(negedge clk) begin
    logic [141:0] act, exp;
    if (m_valid) begin
      act = {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_done, data_done,
             inst_stall, data_stall, inst_rdata, data_rdata};
      exp = {(m_owner != 0) && m_addr_phase, e_wr, e_wstrb, e_addr, e_wdata, e_i_done, e_d_done,
             inst_req & ~e_i_done, data_req & ~e_d_done, e_i_rdata, e_d_rdata};
      checks++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_data_rdata", data_rdata, 32'h0);
    chk("reset_done", {30'd0, inst_done, data_done}, 32'd0);

    // Single load, zero wait cycles: done at cycle 3.
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0010;          // cycle 0
    tick(); chk("load_req_c1", {31'd0, mem_req}, 32'd1);                  // cycle 1
    chk("load_addr_c1", mem_addr, 32'h0000_0010); mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("load_req_c2", {31'd0, mem_req}, 32'd0);
    tick(); mem_data_ok = 1'b0;                                           // cycle 3
    chk("load_done_c3", {31'd0, data_done}, 32'd1);
    chk("load_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("load_wr", {31'd0, mem_wr}, 32'd0);
    chk("load_stall_c3", {31'd0, data_stall}, 32'd0);
    tick(); data_req = 1'b0;
    chk("load_done_pulse", {31'd0, data_done}, 32'd0);
    tick();

    // Store, wstrb 0100, address accepted after 2 extra cycles: done at cycle 5.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0100; data_addr = 32'h22;
    data_wdata = 32'hA5A5_0000;
    tick(); tick(); tick();                                               // cycle 3
    chk("store_wstrb_c3", {28'd0, mem_wstrb}, 32'h4);
    chk("store_wr_c3", {31'd0, mem_wr}, 32'd1);
    chk("store_req_c3", {31'd0, mem_req}, 32'd1);
    mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick(); mem_data_ok = 1'b0;                                           // cycle 5
    chk("store_done_c5", {31'd0, data_done}, 32'd1);
    tick(); data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    tick();

    // Both ports request together: data first, fetch granted afterwards.
    data_req = 1'b1; data_addr = 32'h40; inst_req = 1'b1; inst_addr = 32'h100;
    tick(); chk("both_data_first", mem_addr, 32'h40); mem_addr_ok = 1'b1; // cycle 1
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    tick(); mem_data_ok = 1'b0;                                           // cycle 3
    chk("both_data_done", {31'd0, data_done}, 32'd1);
    chk("both_inst_stall_c3", {31'd0, inst_stall}, 32'd1);
    tick(); data_req = 1'b0;                                              // cycle 4
    chk("both_gap_c4", {31'd0, mem_req}, 32'd0);
    tick(); chk("both_inst_req_c5", {31'd0, mem_req}, 32'd1);             // cycle 5
    chk("both_inst_addr", mem_addr, 32'h100);
    mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h2222_2222;
    chk("both_inst_stall_c6", {31'd0, inst_stall}, 32'd1);
    tick(); mem_data_ok = 1'b0;                                           // cycle 7
    chk("both_inst_done", {31'd0, inst_done}, 32'd1);
    chk("both_inst_rdata", inst_rdata, 32'h2222_2222);
    chk("both_data_rdata_kept", data_rdata, 32'h1111_1111);
    tick(); inst_req = 1'b0;
    tick();

    // Address change during the wait phase is ignored; stray data_ok in IDLE too.
    data_req = 1'b1; data_addr = 32'h80; data_wdata = 32'h1234_5678;
    tick(); mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; data_addr = 32'hFFFF_FFFC; data_wdata = 32'h0;  // cycle 2
    tick(); chk("frozen_addr", mem_addr, 32'h80); mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick(); mem_data_ok = 1'b0;
    chk("frozen_done", {31'd0, data_done}, 32'd1);
    tick(); data_req = 1'b0;
    tick(); mem_data_ok = 1'b1;
    tick(); mem_data_ok = 1'b0;
    chk("spurious_ok_done", {30'd0, inst_done, data_done}, 32'd0);
    tick();

    // Reset during fetch wait phase, stray data_ok drained, then normal fetch.
    inst_req = 1'b1; inst_addr = 32'h300;
    tick(); mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; rst = 1'b1;                               // cycle 2
    tick(); rst = 1'b0;                                                   // cycle 3
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    tick(); mem_data_ok = 1'b1; mem_rdata = 32'hBAAD_BAAD;                // cycle 4
    chk("drain_no_grant", {31'd0, mem_req}, 32'd0);
    tick(); mem_data_ok = 1'b0;                                           // cycle 5
    chk("drain_no_done", {31'd0, inst_done}, 32'd0);
    tick(); chk("after_drain_req", {31'd0, mem_req}, 32'd1);              // cycle 6
    chk("after_drain_addr", mem_addr, 32'h300);
    mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3333_3333;
    tick(); mem_data_ok = 1'b0;                                           // cycle 8
    chk("after_drain_done", {31'd0, inst_done}, 32'd1);
    chk("after_drain_rdata", inst_rdata, 32'h3333_3333);
    tick(); inst_req = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
